// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants and types for the memory-port arbiter:
//   - requester index assignments (which block sits on which request lane)
//   - FSM state encoding
//   - bit positions inside the sticky arb_error vector
//   - fixed field widths (grant index, mem_func, error vector)
//   - next_ptr(): round-robin pointer advance with wrap at NREQ
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Requester lane assignments
    localparam int REQ_TRAVERSAL = 0;
    localparam int REQ_EXECUTE   = 1;
    localparam int REQ_CELL      = 2;
    localparam int REQ_SPARE     = 3;

    // Error flag bit positions inside arb_error
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_DROP     = 1;
    localparam int ERR_SPURIOUS = 2;

    // Fixed widths
    localparam int IDX_W  = 3;
    localparam int FUNC_W = 2;
    localparam int ERR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Advance the round-robin pointer past the last owner. An explicit compare
    // is used instead of a modulo so non-power-of-two NREQ wraps to 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur,
                                                   input int nreq);
        if (int'(cur) >= nreq - 1) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Memory unit port bundle: execute/ready handshake, two address lanes,
// 2-bit function code, write data and two read-data lanes.
//   master : driven by the arbiter (command out, completion/read data in)
//   slave  : seen by the memory unit (command in, completion/read data out)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    import mem_arbiter_pkg::*;

    logic              mem_execute;
    logic [ADDR_W-1:0] address1;
    logic [ADDR_W-1:0] address2;
    logic [FUNC_W-1:0] mem_func;
    logic [DATA_W-1:0] write_data;
    logic              mem_ready;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output mem_execute, address1, address2, mem_func, write_data,
        input  mem_ready, read_data1, read_data2
    );

    modport slave (
        input  mem_execute, address1, address2, mem_func, write_data,
        output mem_ready, read_data1, read_data2
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr_pick
// Combinational round-robin picker: returns the first set bit of req found by
// scanning upward from ptr and wrapping at NREQ.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : scan start position (always < NREQ)
//   valid : at least one request bit is set
//   idx   : index of the chosen requester (0 when valid is low)
// ---------------------------------------------------------------------------
module mem_arbiter_rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int pos;

    // Scan from the farthest offset back toward ptr so the closest set bit
    // is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if ((req & (NREQ'(1) << pos)) != '0) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory unit port among NREQ requesters (traversal, execute,
// cell block, spare) with round-robin grant and one outstanding operation.
// The winner's command is latched at grant time and driven to memory; the
// completion pulse and read data are returned to the winner only.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   req_execute     : per-requester request, held until its req_ready pulse
//   req_address1/2  : flattened per-requester addresses (slice i = req i)
//   req_func        : flattened per-requester 2-bit mem_func
//   req_write_data  : flattened per-requester write data
//   req_ready       : one-cycle completion pulse to the owner
//   rd_data1/2      : registered read data, valid with req_ready
//   mem             : memory unit port (master side)
//   grant_id        : current or last owner index
//   busy            : high in every state except IDLE
//   arb_error       : sticky flags [0]=timeout [1]=owner drop [2]=spurious
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_execute,
    input  logic [NREQ*ADDR_W-1:0]   req_address1,
    input  logic [NREQ*ADDR_W-1:0]   req_address2,
    input  logic [NREQ*FUNC_W-1:0]   req_func,
    input  logic [NREQ*DATA_W-1:0]   req_write_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        rd_data1,
    output logic [DATA_W-1:0]        rd_data2,
    mem_arbiter_if.master            mem,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy,
    output logic [ERR_W-1:0]         arb_error
);

    localparam int TO_W = $clog2(TIMEOUT) + 1;

    arb_state_t        state;
    arb_state_t        state_next;
    logic [IDX_W-1:0]  rr_ptr;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    logic [ADDR_W-1:0] sel_addr1;
    logic [ADDR_W-1:0] sel_addr2;
    logic [FUNC_W-1:0] sel_func;
    logic [DATA_W-1:0] sel_wdata;

    logic [ADDR_W-1:0] cmd_addr1;
    logic [ADDR_W-1:0] cmd_addr2;
    logic [FUNC_W-1:0] cmd_func;
    logic [DATA_W-1:0] cmd_wdata;

    logic [NREQ-1:0]   owner_mask;
    logic              owner_req;
    logic              mem_exec;
    logic [TO_W-1:0]   timeout_cnt;
    logic [2:0]        err_flags;

    mem_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req_execute),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A shift mask avoids indexing the NREQ-wide vectors with the wider grant_id.
    assign owner_mask = NREQ'(1) << grant_id;
    assign owner_req  = |(req_execute & owner_mask);

    // Select the picked requester's command fields from the flattened buses.
    always_comb begin
        sel_addr1 = req_address1[ADDR_W-1:0];
        sel_addr2 = req_address2[ADDR_W-1:0];
        sel_func  = req_func[FUNC_W-1:0];
        sel_wdata = req_write_data[DATA_W-1:0];
        for (int i = 1; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr1 = req_address1[i*ADDR_W +: ADDR_W];
                sel_addr2 = req_address2[i*ADDR_W +: ADDR_W];
                sel_func  = req_func[i*FUNC_W +: FUNC_W];
                sel_wdata = req_write_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register; reset drops straight back to IDLE mid-operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant, issue, wait for completion, one dead cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.mem_ready) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; req_ready lands in RELEASE, the cycle after
    // mem_ready, which gives the owner a full cycle to drop its request.
    always_comb begin
        mem_exec  = 1'b0;
        busy      = 1'b1;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_ISSUE, ST_WAIT: begin
                mem_exec = 1'b1;
            end
            ST_RELEASE: begin
                req_ready = owner_mask;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Grant capture, response capture, pointer advance, timeout and errors.
    // The timeout flag is raised on the edge that brings the counter to
    // TIMEOUT-1, so it is visible during that WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id    <= '0;
            cmd_addr1   <= '0;
            cmd_addr2   <= '0;
            cmd_func    <= '0;
            cmd_wdata   <= '0;
            rd_data1    <= '0;
            rd_data2    <= '0;
            rr_ptr      <= '0;
            timeout_cnt <= '0;
            err_flags   <= '0;
        end else begin
            if (state == ST_IDLE && pick_valid) begin
                grant_id  <= pick_idx;
                cmd_addr1 <= sel_addr1;
                cmd_addr2 <= sel_addr2;
                cmd_func  <= sel_func;
                cmd_wdata <= sel_wdata;
            end

            if (state == ST_WAIT && mem.mem_ready) begin
                rd_data1 <= mem.read_data1;
                rd_data2 <= mem.read_data2;
                rr_ptr   <= next_ptr(grant_id, NREQ);
            end

            if (state == ST_WAIT && !mem.mem_ready) begin
                if (timeout_cnt != TO_W'(TIMEOUT - 1)) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
                if (timeout_cnt == TO_W'(TIMEOUT - 2)) begin
                    err_flags[ERR_TIMEOUT] <= 1'b1;
                end
            end else begin
                timeout_cnt <= '0;
            end

            if ((state == ST_ISSUE || state == ST_WAIT) && !owner_req) begin
                err_flags[ERR_DROP] <= 1'b1;
            end

            if (mem.mem_ready && state != ST_WAIT) begin
                err_flags[ERR_SPURIOUS] <= 1'b1;
            end
        end
    end

    assign arb_error       = {{(ERR_W-3){1'b0}}, err_flags};
    assign mem.mem_execute = mem_exec;
    assign mem.address1    = cmd_addr1;
    assign mem.address2    = cmd_addr2;
    assign mem.mem_func    = cmd_func;
    assign mem.write_data  = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of complete transactions
// (single request, 4-way contention, 2-way fairness) plus hand-written
// sequences for reset state, timeout, protocol errors and reset mid-WAIT.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_execute;
    logic [NREQ*ADDR_W-1:0] req_address1;
    logic [NREQ*ADDR_W-1:0] req_address2;
    logic [NREQ*2-1:0]      req_func;
    logic [NREQ*DATA_W-1:0] req_write_data;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W-1:0]      rd_data1;
    logic [DATA_W-1:0]      rd_data2;
    logic [2:0]             grant_id;
    logic                   busy;
    logic [7:0]             arb_error;

    int n_compared   = 0;
    int n_mismatched = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mem_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_execute    (req_execute),
        .req_address1   (req_address1),
        .req_address2   (req_address2),
        .req_func       (req_func),
        .req_write_data (req_write_data),
        .req_ready      (req_ready),
        .rd_data1       (rd_data1),
        .rd_data2       (rd_data2),
        .mem            (mem_bus),
        .grant_id       (grant_id),
        .busy           (busy),
        .arb_error      (arb_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [3:0]  req;
        logic [9:0]  base;
        int          lat;
        logic [63:0] rdata;
        logic [2:0]  exp_grant;
        logic [9:0]  exp_addr1;
        logic [1:0]  exp_func;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Requester i: address1 = base+i, address2 = base+0x100+i,
    // func = (i+3) mod 4, write_data = CAFE.. | base<<16 | i
    task automatic setFields(input logic [9:0] base);
        for (int i = 0; i < NREQ; i++) begin
            req_address1[i*ADDR_W +: ADDR_W]   = base + ADDR_W'(i);
            req_address2[i*ADDR_W +: ADDR_W]   = base + 10'h100 + ADDR_W'(i);
            req_func[i*2 +: 2]                 = 2'(i + 3);
            req_write_data[i*DATA_W +: DATA_W] = 64'hCAFE_0000_0000_0000 |
                                                 (64'(base) << 16) | 64'(i);
        end
    endtask

    // Called at a falling edge; asserts reset at once, releases one cycle later.
    task automatic applyReset();
        rst                = 1'b0;
        req_execute        = '0;
        mem_bus.mem_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One full transaction, entered at a falling edge while the DUT is IDLE.
    task automatic applyStimulus(input vec_t v);
        if (v.rst_before) begin
            applyReset();
        end
        setFields(v.base);
        req_execute = v.req;
        @(negedge clk);
        checkOutput("issue_exec", 64'(mem_bus.mem_execute), 64'd1);
        checkOutput("grant_id", 64'(grant_id), 64'(v.exp_grant));
        checkOutput("address1", 64'(mem_bus.address1), 64'(v.exp_addr1));
        checkOutput("address2", 64'(mem_bus.address2), 64'(v.exp_addr1 + 10'h100));
        checkOutput("mem_func", 64'(mem_bus.mem_func), 64'(v.exp_func));
        checkOutput("write_data", mem_bus.write_data,
                    64'hCAFE_0000_0000_0000 | (64'(v.base) << 16) | 64'(v.exp_grant));
        checkOutput("issue_busy", 64'(busy), 64'd1);
        for (int k = 0; k < v.lat; k++) begin
            @(negedge clk);
            checkOutput("wait_exec", 64'(mem_bus.mem_execute), 64'd1);
            checkOutput("wait_ready", 64'(req_ready), 64'd0);
        end
        mem_bus.mem_ready  = 1'b1;
        mem_bus.read_data1 = v.rdata;
        mem_bus.read_data2 = v.rdata ^ 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        mem_bus.mem_ready  = 1'b0;
        mem_bus.read_data1 = '0;
        mem_bus.read_data2 = '0;
        checkOutput("req_ready", 64'(req_ready), 64'(4'b0001 << v.exp_grant));
        checkOutput("rd_data1", rd_data1, v.rdata);
        checkOutput("rd_data2", rd_data2, v.rdata ^ 64'hFFFF_0000_FFFF_0000);
        checkOutput("release_exec", 64'(mem_bus.mem_execute), 64'd0);
        @(negedge clk);
        checkOutput("idle_ready", 64'(req_ready), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_error", 64'(arb_error), 64'd0);
        checkOutput("rd_data1_hold", rd_data1, v.rdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        // single request, then contention (0,1,2,3,0), then fairness on 0/2
        vecs[0] = '{1'b0, 4'b0010, 10'h004, 3, 64'hDEAD, 3'(REQ_EXECUTE), 10'h005, 2'd0};
        vecs[1] = '{1'b1, 4'b1111, 10'h020, 1, 64'h1111, 3'd0, 10'h020, 2'd3};
        vecs[2] = '{1'b0, 4'b1111, 10'h020, 2, 64'h2222, 3'd1, 10'h021, 2'd0};
        vecs[3] = '{1'b0, 4'b1111, 10'h020, 3, 64'h3333, 3'd2, 10'h022, 2'd1};
        vecs[4] = '{1'b0, 4'b1111, 10'h020, 1, 64'h4444, 3'd3, 10'h023, 2'd2};
        vecs[5] = '{1'b0, 4'b1111, 10'h020, 2, 64'h5555, 3'd0, 10'h020, 2'd3};
        vecs[6] = '{1'b0, 4'b0101, 10'h030, 1, 64'h6666, 3'd2, 10'h032, 2'd1};
        vecs[7] = '{1'b0, 4'b0101, 10'h030, 2, 64'h7777, 3'd0, 10'h030, 2'd3};
        vecs[8] = '{1'b0, 4'b0101, 10'h030, 1, 64'h8888, 3'd2, 10'h032, 2'd1};
        vecs[9] = '{1'b0, 4'b0101, 10'h030, 3, 64'h9999, 3'd0, 10'h030, 2'd3};

        rst                = 1'b0;
        req_execute        = '0;
        req_address1       = '0;
        req_address2       = '0;
        req_func           = '0;
        req_write_data     = '0;
        mem_bus.mem_ready  = 1'b0;
        mem_bus.read_data1 = '0;
        mem_bus.read_data2 = '0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_exec", 64'(mem_bus.mem_execute), 64'd0);
        checkOutput("rst_addr1", 64'(mem_bus.address1), 64'd0);
        checkOutput("rst_wdata", mem_bus.write_data, 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rd1", rd_data1, 64'd0);
        checkOutput("rst_grant", 64'(grant_id), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_error", 64'(arb_error), 64'd0);
        rst = 1'b1;

        for (int n = 0; n < 10; n++) begin
            applyStimulus(vecs[n]);
        end

        // Timeout: requester 3 alone, memory silent for 10 WAIT cycles
        applyReset();
        setFields(10'h050);
        req_execute = 4'b1000;
        @(negedge clk);
        checkOutput("to_grant", 64'(grant_id), 64'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) begin
                checkOutput("to_err_early", 64'(arb_error[0]), 64'd0);
            end
            if (k == 8) begin
                checkOutput("to_err_set", 64'(arb_error[0]), 64'd1);
                checkOutput("to_exec_held", 64'(mem_bus.mem_execute), 64'd1);
            end
        end
        mem_bus.mem_ready  = 1'b1;
        mem_bus.read_data1 = 64'hBEEF;
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        req_execute       = '0;
        checkOutput("to_late_ready", 64'(req_ready), 64'b1000);
        checkOutput("to_late_rd1", rd_data1, 64'hBEEF);
        checkOutput("to_err_only", 64'(arb_error), 64'h01);
        @(negedge clk);

        // Owner drops req_execute in WAIT
        applyReset();
        setFields(10'h060);
        req_execute = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        req_execute = '0;
        @(negedge clk);
        checkOutput("drop_err", 64'(arb_error), 64'h02);
        checkOutput("drop_exec", 64'(mem_bus.mem_execute), 64'd1);
        mem_bus.mem_ready  = 1'b1;
        mem_bus.read_data1 = 64'h77;
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        checkOutput("drop_ready", 64'(req_ready), 64'b0001);
        checkOutput("drop_rd1", rd_data1, 64'h77);
        @(negedge clk);
        checkOutput("drop_idle_ready", 64'(req_ready), 64'd0);

        // mem_ready while IDLE
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        checkOutput("spur_err", 64'(arb_error), 64'h06);
        checkOutput("spur_ready", 64'(req_ready), 64'd0);
        checkOutput("spur_busy", 64'(busy), 64'd0);

        // Reset in the middle of WAIT; rr_ptr is 1 here so requester 2 wins
        req_execute = 4'b0100;
        @(negedge clk);
        checkOutput("mid_grant", 64'(grant_id), 64'd2);
        @(negedge clk);
        @(negedge clk);
        rst               = 1'b0;
        mem_bus.mem_ready = 1'b1;
        #1;
        checkOutput("mid_exec", 64'(mem_bus.mem_execute), 64'd0);
        checkOutput("mid_busy", 64'(busy), 64'd0);
        checkOutput("mid_error", 64'(arb_error), 64'd0);
        checkOutput("mid_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst               = 1'b1;
        mem_bus.mem_ready = 1'b0;
        req_execute       = '0;
        @(negedge clk);
        checkOutput("post_ready", 64'(req_ready), 64'd0);
        checkOutput("post_busy", 64'(busy), 64'd0);
        v = '{1'b0, 4'b0101, 10'h070, 2, 64'h1234, 3'd0, 10'h070, 2'd3};
        applyStimulus(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory unit port (execute/ready handshake, two address/data lanes, 2-bit func) among NREQ requesters: traversal, execute, cell block, and one spare.
- Round-robin grant with exactly one outstanding memory operation.
- Muxes the winner's command onto the memory port and routes mem_ready back to the winner only.
- Sits between the requester blocks and memory_unit, replacing per-block hard wiring.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 10, memory address width; must equal the memory unit address width
DATA_W, 64, memory data width; must equal the memory unit data width
TIMEOUT, 1024, cycles to wait for mem_ready before flagging an error (≥2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_execute  in  NREQ  per-requester request, held high until its req_ready pulse
req_address1  in  NREQ*ADDR_W  flattened; slice i = requester i
req_address2  in  NREQ*ADDR_W  flattened
req_func  in  NREQ*2  flattened mem_func per requester
req_write_data  in  NREQ*DATA_W  flattened
req_ready  out  NREQ  one-cycle completion pulse to the owner
rd_data1  out  DATA_W  registered read_data1, shared by all requesters, valid with req_ready
rd_data2  out  DATA_W  registered read_data2, valid with req_ready
mem_execute  out  1  to memory unit
address1  out  ADDR_W  to memory unit
address2  out  ADDR_W  to memory unit
mem_func  out  2  to memory unit
write_data  out  DATA_W  to memory unit
mem_ready  in  1  one-cycle completion pulse from memory unit
read_data1  in  DATA_W  from memory unit, valid with mem_ready
read_data2  in  DATA_W  from memory unit, valid with mem_ready
grant_id  out  3  current or last owner index
busy  out  1  high in every state except IDLE
arb_error  out  8  sticky error flags

Behaviour:
- Reset (async, rst low): all outputs 0; state=IDLE; rr_ptr=0; timeout counter=0. Reset mid-operation drops mem_execute immediately and discards the pending response.
- States:
  - IDLE: if any req_execute, pick the winner: the first set bit scanning from rr_ptr upward, wrapping at NREQ. Register grant_id=winner, latch the winner's address1/address2/mem_func/write_data, go to ISSUE.
  - ISSUE: mem_execute=1; outputs hold the latched values; go to WAIT.
  - WAIT: mem_execute stays 1. On mem_ready:
    - next cycle: mem_execute=0, rd_data1/2 take read_data1/2, req_ready[grant_id]=1 for exactly one cycle;
    - rr_ptr=(grant_id+1) mod NREQ;
    - go to RELEASE.
  - RELEASE: one dead cycle so the owner can deassert req_execute; req_ready=0; go to IDLE.
- Latency: request seen in IDLE at cycle t gives mem_execute at t+1. mem_ready at cycle m gives req_ready at m+1. Minimum back-to-back spacing is 4 cycles plus memory latency.
- Command fields are latched in IDLE. Requester changes after the grant have no effect.
- Non-owners' req_execute is ignored while busy; they wait. There is no starvation: each requester is served within NREQ grants.
- Timeout: the counter increments in WAIT and clears on leaving WAIT. At TIMEOUT-1, set arb_error[0]. The arbiter keeps waiting and does not abort.
- Owner deasserting req_execute in ISSUE/WAIT sets arb_error[1]. The operation still completes and req_ready still pulses.
- mem_ready outside WAIT sets arb_error[2] and is otherwise ignored.
- arb_error[7:3]=0. Error bits clear only on reset.
- Out-of-range rr_ptr cannot occur; NREQ non-power-of-2 wraps to 0.

Decomposition:
- Shared header mem_arbiter.vh holds:
  - requester index constants: REQ_TRAVERSAL=0, REQ_EXECUTE=1, REQ_CELL=2, REQ_SPARE=3;
  - state encodings: IDLE=0, ISSUE=1, WAIT=2, RELEASE=3;
  - error bit positions: ERR_TIMEOUT=0, ERR_DROP=1, ERR_SPURIOUS=2.
- Widths come from memory_unit.vh.
- One sub-module: rr_pick, a combinational round-robin first-set-from-pointer picker (inputs: request vector, rr_ptr; outputs: valid, index).

Test Plan:
- Single request: req_execute[1]=1, addr1=0x005, func=0; memory returns mem_ready 3 cycles after mem_execute with read_data1=0xDEAD → mem_execute high at t+1 with address1=0x005; req_ready=4'b0010 for one cycle; rd_data1=0xDEAD.
- Contention: all 4 requesters assert at once and re-request after each ready → grant order 0,1,2,3,0; each req_ready pulses exactly once per grant.
- Fairness: requesters 0 and 2 continuously requesting → grants alternate 0,2,0,2; requester 2 never waits more than 1 grant.
- Timeout: TIMEOUT=8, memory never responds → arb_error[0]=1 on the 8th WAIT cycle; mem_execute stays high; a late mem_ready completes normally.
- Protocol errors: owner drops req_execute in WAIT → arb_error[1]=1 and req_ready still pulses. mem_ready in IDLE → arb_error[2]=1 and no req_ready.
- Reset mid-WAIT: rst low for 1 cycle → mem_execute=0, busy=0, arb_error=0, no req_ready. Next request is served from rr_ptr=0.
